rr_reqctrl: RTL and testbench

Reconfiguration-side initiator for the `rc_reqn`/`rc_ackn` handshake used by every reconfigurable module in the XDRS design (e.g. the low-pass filter region). On a software request it asks the active module to drain and synchronise, then isolates the region and triggers the bitstream transfer. After the transfer it holds the new module in reset and releases the region. This block is the requester; the reconfigurable module's pipeline-sync logic is the responder.

---
 rtl/rr_reqctrl_pkg.sv | 18 +
 rtl/rr_cycle_counter.sv | 26 ++
 rtl/rr_reqctrl.sv | 141 ++++++++++++++
 tb/tb_rr_reqctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_reqctrl_pkg.sv
// Shared types and helpers for the reconfiguration request controller.
package rr_reqctrl_pkg;

  // Controller states, 3-bit encoding shared by every file of the block.
  typedef enum logic [2:0] {
    RR_S_IDLE = 3'd0,
    RR_S_REQ  = 3'd1,
    RR_S_XFER = 3'd2,
    RR_S_RST  = 3'd3,
    RR_S_REL  = 3'd4
  } rr_state_e;

  // Larger of two elaboration-time integers, used to size the shared counter.
  function automatic int rr_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_cycle_counter.sv
// Loadable saturating down-counter shared by the ack timeout and the reset hold.
module rr_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/rr_reqctrl.sv
// Requester side of the rc_reqn/rc_ackn handshake: drains the active region,
// isolates it, triggers the bitstream load, then resets and releases it.
module rr_reqctrl
  import rr_reqctrl_pkg::*;
#(
  parameter int C_RRID_WIDTH = 4,
  parameter int C_TIMEOUT    = 1024,
  parameter int C_RSTCNT     = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_start,
  input  logic [C_RRID_WIDTH-1:0] sw_rrid,
  output logic                    sw_busy,
  output logic                    sw_done,
  output logic                    sw_err,
  output logic                    rc_reqn,
  input  logic                    rc_ackn,
  output logic                    rr_isolate,
  output logic                    rr_rstn,
  output logic                    xfer_start,
  output logic [C_RRID_WIDTH-1:0] xfer_rrid,
  input  logic                    xfer_done
);

  localparam int CNT_W = $clog2(rr_max(C_TIMEOUT, C_RSTCNT) + 1);
  localparam bit TIMEOUT_EN = (C_TIMEOUT > 0);
  // Loading N-1 makes the terminal edge land exactly N cycles after entry.
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = (C_TIMEOUT > 0) ? CNT_W'(C_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] RSTCNT_LOAD  = CNT_W'(C_RSTCNT - 1);

  rr_state_e        state;
  logic             accept_start;
  logic             ack_seen;
  logic             timeout_hit;
  logic             xfer_finish;
  logic             rst_finish;
  logic             rel_finish;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_init;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  rr_cycle_counter #(
    .WIDTH(CNT_W)
  ) u_counter (
    .clk       (clk),
    .rstn      (rstn),
    .load      (cnt_load),
    .load_value(cnt_init),
    .value     (cnt_value),
    .zero      (cnt_zero)
  );

  // Transition conditions, shared by the FSM and the counter reload on every state entry.
  always_comb begin
    accept_start = (state == RR_S_IDLE) && sw_start;
    ack_seen     = (state == RR_S_REQ) && !rc_ackn;
    timeout_hit  = (state == RR_S_REQ) && rc_ackn && TIMEOUT_EN && (cnt_value == '0);
    xfer_finish  = (state == RR_S_XFER) && xfer_done && !xfer_start;
    rst_finish   = (state == RR_S_RST) && cnt_zero;
    rel_finish   = (state == RR_S_REL) && rc_ackn;
    cnt_load     = accept_start | ack_seen | timeout_hit | xfer_finish | rst_finish | rel_finish;
    cnt_init     = '0;
    if (accept_start) begin
      cnt_init = TIMEOUT_LOAD;
    end else if (xfer_finish) begin
      cnt_init = RSTCNT_LOAD;
    end
  end

  // Main sequencer with all region and software outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RR_S_IDLE;
      rc_reqn    <= 1'b1;
      rr_isolate <= 1'b0;
      rr_rstn    <= 1'b0;
      sw_busy    <= 1'b0;
      sw_done    <= 1'b0;
      sw_err     <= 1'b0;
      xfer_start <= 1'b0;
      xfer_rrid  <= '0;
    end else begin
      sw_done    <= 1'b0;
      sw_err     <= 1'b0;
      xfer_start <= 1'b0;
      case (state)
        RR_S_IDLE: begin
          rr_rstn <= 1'b1;
          if (accept_start) begin
            xfer_rrid <= sw_rrid;
            rc_reqn   <= 1'b0;
            sw_busy   <= 1'b1;
            state     <= RR_S_REQ;
          end
        end
        RR_S_REQ: begin
          if (ack_seen) begin
            rr_isolate <= 1'b1;
            xfer_start <= 1'b1;
            state      <= RR_S_XFER;
          end else if (timeout_hit) begin
            sw_err  <= 1'b1;
            rc_reqn <= 1'b1;
            sw_busy <= 1'b0;
            state   <= RR_S_IDLE;
          end
        end
        RR_S_XFER: begin
          if (xfer_finish) begin
            rr_rstn <= 1'b0;
            rc_reqn <= 1'b1;
            state   <= RR_S_RST;
          end
        end
        RR_S_RST: begin
          if (rst_finish) begin
            rr_rstn    <= 1'b1;
            rr_isolate <= 1'b0;
            state      <= RR_S_REL;
          end
        end
        RR_S_REL: begin
          if (rel_finish) begin
            sw_done <= 1'b1;
            sw_busy <= 1'b0;
            state   <= RR_S_IDLE;
          end
        end
        default: begin
          rc_reqn    <= 1'b1;
          rr_isolate <= 1'b0;
          sw_busy    <= 1'b0;
          state      <= RR_S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_reqctrl.sv
// Self-checking bench for rr_reqctrl: directed swap scenarios with randomized
// delays and noise, checked every cycle against an interval-based timing model.
module tb_rr_reqctrl;

  localparam int RRID_W  = 4;
  localparam int TIMEOUT = 8;
  localparam int RSTCNT  = 16;
  localparam int INF     = 1000000000;
  localparam logic [10:0] RESET_VEC = 11'h080;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              sw_start = 1'b0;
  logic [RRID_W-1:0] sw_rrid = '0;
  logic              rc_ackn = 1'b1;
  logic              xfer_done = 1'b0;
  logic              sw_busy, sw_done, sw_err, rc_reqn, rr_isolate, rr_rstn, xfer_start;
  logic [RRID_W-1:0] xfer_rrid;
  logic [10:0]       outs;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: edge numbers at which each phase of the current request began.
  int t_start = INF;
  int t_ack   = INF;
  int t_done  = INF;
  int t_rel   = INF;
  int t_err   = INF;
  logic [RRID_W-1:0] m_rrid = '0;

  rr_reqctrl #(
    .C_RRID_WIDTH(RRID_W),
    .C_TIMEOUT   (TIMEOUT),
    .C_RSTCNT    (RSTCNT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sw_start  (sw_start),
    .sw_rrid   (sw_rrid),
    .sw_busy   (sw_busy),
    .sw_done   (sw_done),
    .sw_err    (sw_err),
    .rc_reqn   (rc_reqn),
    .rc_ackn   (rc_ackn),
    .rr_isolate(rr_isolate),
    .rr_rstn   (rr_rstn),
    .xfer_start(xfer_start),
    .xfer_rrid (xfer_rrid),
    .xfer_done (xfer_done)
  );

  assign outs = {sw_busy, sw_done, sw_err, rc_reqn, rr_isolate, rr_rstn, xfer_start, xfer_rrid};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic bit in_req(input int c);
    return (t_start <= c) && (c < t_ack) && (c < t_err);
  endfunction

  function automatic bit in_xfer(input int c);
    return (t_ack <= c) && (c < t_done);
  endfunction

  function automatic bit in_rst(input int c);
    return (t_done <= c) && (c < t_done + RSTCNT);
  endfunction

  function automatic bit in_rel(input int c);
    return (t_done + RSTCNT <= c) && (c < t_rel);
  endfunction

  // Expected outputs in the cycle following edge c, from the phase intervals.
  function automatic logic [10:0] model_out(input int c);
    logic busy, done, err, reqn, iso, rrst, xs;
    reqn = !((t_start <= c) && (c < t_done) && (c < t_err));
    iso  = (t_ack <= c) && (c < t_done + RSTCNT);
    rrst = !in_rst(c);
    xs   = (c == t_ack);
    done = (c == t_rel);
    err  = (c == t_err);
    busy = (t_start <= c) && (c < t_err) && (c < t_rel);
    return {busy, done, err, reqn, iso, rrst, xs, m_rrid};
  endfunction

  task automatic model_reset();
    t_start = INF; t_ack = INF; t_done = INF; t_rel = INF; t_err = INF;
    m_rrid = '0;
  endtask

  // Advance the model across the edge following cycle c with the given inputs.
  task automatic model_edge(input int c, input logic st, input logic [RRID_W-1:0] id,
                            input logic ackn, input logic dn);
    int e;
    e = c + 1;
    if (in_req(c)) begin
      if (!ackn) begin
        t_ack = e;
        t_err = INF;
      end
    end else if (in_xfer(c)) begin
      if (dn && (c != t_ack)) t_done = e;
    end else if (in_rst(c)) begin
      // reset hold runs on its own
    end else if (in_rel(c)) begin
      if (ackn) t_rel = e;
    end else if (st) begin
      t_start = e;
      t_ack   = INF;
      t_done  = INF;
      t_rel   = INF;
      t_err   = (TIMEOUT > 0) ? e + TIMEOUT : INF;
      m_rrid  = id;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h (busy,done,err,reqn,iso,rstn,xs,rrid)",
             tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, then compare against the model.
  task automatic applyStimulus(input logic st, input logic [RRID_W-1:0] id,
                               input logic ackn, input logic dn);
    sw_start  = st;
    sw_rrid   = id;
    rc_ackn   = ackn;
    xfer_done = dn;
    model_edge(cyc, st, id, ackn, dn);
    @(posedge clk);
    cyc++;
    #1;
    checkOutput($sformatf("cyc%0d", cyc), outs, model_out(cyc));
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One full request: ack after ack_dly, done after the transfer, release after rel_hold.
  task automatic run_swap(input logic [RRID_W-1:0] id, input int ack_dly, input int xfer_dly,
                          input int rel_hold, input bit noise, input int abort_rst);
    applyStimulus(1'b1, id, 1'b1, 1'b0);
    for (int i = 1; i < ack_dly; i++)
      applyStimulus(noise & rbit(), 4'd7, 1'b1, noise & rbit());
    applyStimulus(1'b0, id, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd7, noise ? rbit() : 1'b0, noise);
    for (int i = 1; i < xfer_dly; i++)
      applyStimulus(noise & ((i == 1) | rbit()), 4'd7, noise ? rbit() : 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd7, 1'b0, 1'b1);
    for (int i = 0; i < RSTCNT; i++) begin
      if (i == abort_rst) return;
      applyStimulus(noise & rbit(), 4'd7, (rel_hold > 0) ? 1'b0 : ((i == RSTCNT - 1) | rbit()),
                    noise & rbit());
    end
    for (int i = 0; i < rel_hold; i++)
      applyStimulus(1'b0, 4'd7, 1'b0, noise & rbit());
    applyStimulus(1'b0, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 4'd7, 1'b1, rbit());
  endtask

  initial begin
    model_reset();
    #12;
    checkOutput("reset_values", outs, RESET_VEC);
    @(negedge clk) rstn = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b1, rbit());

    $display("[TB] normal swap");
    run_swap(4'd3, 5, 100, 0, 1'b0, -1);

    $display("[TB] busy drop and masked glitches");
    run_swap(4'd3, $urandom_range(1, 7), $urandom_range(20, 60), 0, 1'b1, -1);

    $display("[TB] ack timeout");
    applyStimulus(1'b1, 4'd9, 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT + 3; i++) applyStimulus(1'b0, 4'd9, 1'b1, rbit());
    run_swap(4'd2, 2, 4, 0, 1'b0, -1);

    $display("[TB] late release");
    run_swap(4'($urandom_range(0, 15)), $urandom_range(1, 7), 10, 20, 1'b0, -1);

    $display("[TB] reset during region reset hold");
    run_swap(4'd5, 3, 10, 0, 1'b0, 6);
    sw_start = 1'b0; rc_ackn = 1'b1; xfer_done = 1'b0;
    #2 rstn = 1'b0;
    #1 checkOutput("reset_async", outs, RESET_VEC);
    model_reset();
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_hold", outs, RESET_VEC);
    @(negedge clk) rstn = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    run_swap(4'd6, 2, 5, 0, 1'b0, -1);

    $display("[TB] randomized swaps");
    for (int k = 0; k < 4; k++)
      run_swap(4'($urandom_range(0, 15)), $urandom_range(1, 7), $urandom_range(2, 30),
               $urandom_range(0, 5), 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
